// File: rtl/baud_tick_gen.sv
// baud_tick_gen
//
// Purpose:
//   Baud-rate tick generator with a fractional divisor. It produces a
//   one-cycle oversample tick (tick_os) once per divisor period and a bit
//   tick (tick_bit) on every OVERSAMPLE-th oversample tick. The divisor can
//   be reprogrammed at runtime through a shadow register that only takes
//   effect at a period boundary, so a running period is never cut short or
//   stretched. A sync pulse restarts the phase, which lets the UART receiver
//   align sampling to a start-bit edge.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous active-high reset, dominates every other input
//   en           count enable; when low, all counting state holds
//   sync         phase restart pulse
//   div_wr       divisor write strobe
//   div_int_in   new integer divisor
//   div_frac_in  new fractional divisor (fraction = div_frac_in / 2^FRAC_W)
//   div_pending  shadow divisor written but not yet applied
//   tick_os      oversample tick, one-cycle pulse
//   tick_bit     bit tick, one-cycle pulse, always coincident with tick_os

module baud_tick_gen #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVERSAMPLE = 16,
  parameter int RESET_DIV  = 324,
  parameter int RESET_FRAC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_int_in,
  input  logic [FRAC_W-1:0] div_frac_in,
  output logic              div_pending,
  output logic              tick_os,
  output logic              tick_bit
);

  // The cycle counter must reach div_int + carry, which can be 2^DIV_W,
  // so it is one bit wider than the divisor.
  localparam int CNT_W = DIV_W + 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0]  cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [FRAC_W-1:0] frac_acc;
  logic              carry;

  logic [DIV_W-1:0]  div_int_act;
  logic [FRAC_W-1:0] div_frac_act;
  logic [DIV_W-1:0]  div_int_sh;
  logic [FRAC_W-1:0] div_frac_sh;

  logic [CNT_W-1:0]  limit;
  logic              wrap;
  logic              os_end;
  logic [FRAC_W-1:0] frac_next;
  logic [FRAC_W:0]   frac_sum;

  // Period end detection and the fractional accumulator step.
  // The shadow always holds the most recently written divisor (it equals the
  // active divisor whenever nothing is pending), so the divisor that governs
  // the period after a wrap is either the incoming write or the shadow.
  // The >= compare keeps the counter from running away when a smaller
  // divisor is applied directly while the count is held with en low.
  always_comb begin
    limit     = CNT_W'(div_int_act) + CNT_W'(carry);
    wrap      = en && (cnt >= limit);
    os_end    = (os_cnt == OS_LAST);
    frac_next = div_wr ? div_frac_in : div_frac_sh;
    frac_sum  = {1'b0, frac_acc} + {1'b0, frac_next};
  end

  // Counters, divisor registers and registered tick outputs.
  // Priority is reset, then sync, then normal counting. Sync also applies
  // any pending shadow so the restarted phase uses the latest divisor.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      os_cnt       <= '0;
      frac_acc     <= '0;
      carry        <= 1'b0;
      div_int_act  <= DIV_W'(RESET_DIV);
      div_frac_act <= FRAC_W'(RESET_FRAC);
      div_int_sh   <= DIV_W'(RESET_DIV);
      div_frac_sh  <= FRAC_W'(RESET_FRAC);
      div_pending  <= 1'b0;
      tick_os      <= 1'b0;
      tick_bit     <= 1'b0;
    end else if (sync) begin
      cnt         <= '0;
      os_cnt      <= '0;
      frac_acc    <= '0;
      carry       <= 1'b0;
      div_pending <= 1'b0;
      tick_os     <= 1'b0;
      tick_bit    <= 1'b0;
      if (div_wr) begin
        div_int_sh   <= div_int_in;
        div_frac_sh  <= div_frac_in;
        div_int_act  <= div_int_in;
        div_frac_act <= div_frac_in;
      end else begin
        div_int_act  <= div_int_sh;
        div_frac_act <= div_frac_sh;
      end
    end else begin
      tick_os  <= wrap;
      tick_bit <= wrap && os_end;

      if (wrap) begin
        cnt               <= '0;
        {carry, frac_acc} <= frac_sum;
        os_cnt            <= os_end ? '0 : os_cnt + OS_W'(1);
      end else if (en) begin
        cnt <= cnt + CNT_W'(1);
      end

      // A write lands in the shadow; it goes live immediately when there is
      // no running period to protect (at a wrap, or while counting is held).
      if (div_wr) begin
        div_int_sh  <= div_int_in;
        div_frac_sh <= div_frac_in;
        if (wrap || !en) begin
          div_int_act  <= div_int_in;
          div_frac_act <= div_frac_in;
          div_pending  <= 1'b0;
        end else begin
          div_pending <= 1'b1;
        end
      end else if (wrap) begin
        div_int_act  <= div_int_sh;
        div_frac_act <= div_frac_sh;
        div_pending  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen
//
// Purpose:
//   Directed self-checking bench for baud_tick_gen with the default
//   parameters (DIV_W 16, FRAC_W 4, OVERSAMPLE 16, reset divisor 324 / 8).
//   Expected tick periods are hand-computed from the divisor settings.
//
// Ports: none (top-level bench).

module tb_baud_tick_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int TICK_BOUND = 2000;

  logic              clk;
  logic              reset;
  logic              en;
  logic              sync;
  logic              div_wr;
  logic [DIV_W-1:0]  div_int_in;
  logic [FRAC_W-1:0] div_frac_in;
  logic              div_pending;
  logic              tick_os;
  logic              tick_bit;

  int checks = 0;
  int errors = 0;
  int orphanBits = 0;

  baud_tick_gen #(
    .DIV_W(DIV_W),
    .FRAC_W(FRAC_W),
    .OVERSAMPLE(16),
    .RESET_DIV(324),
    .RESET_FRAC(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sync(sync),
    .div_wr(div_wr),
    .div_int_in(div_int_in),
    .div_frac_in(div_frac_in),
    .div_pending(div_pending),
    .tick_os(tick_os),
    .tick_bit(tick_bit)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A bit tick must always coincide with an oversample tick.
  always @(negedge clk) begin
    if (tick_bit && !tick_os) orphanBits++;
  end

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives all inputs at a falling edge and advances one full clock.
  task automatic applyStimulus(input bit r, input bit e, input bit s, input bit w,
                               input int di, input int df);
    reset       = r;
    en          = e;
    sync        = s;
    div_wr      = w;
    div_int_in  = DIV_W'(di);
    div_frac_in = FRAC_W'(df);
    @(negedge clk);
  endtask

  // Counts cycles until tick_os is seen high, bounded so a dead DUT
  // shows up as a wrong period instead of a hang.
  task automatic waitTick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!tick_os && cycles < TICK_BOUND);
  endtask

  initial begin
    int p;
    int total;
    int earlyBits;
    int lastBit;
    int osCount;
    int bitCount;

    reset       = 1'b1;
    en          = 1'b0;
    sync        = 1'b0;
    div_wr      = 1'b0;
    div_int_in  = '0;
    div_frac_in = '0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("reset_tick_os", int'(tick_os), 0);
    checkOutput("reset_tick_bit", int'(tick_bit), 0);
    checkOutput("reset_pending", int'(div_pending), 0);

    // Test 1: div 3/0 written while disabled, ticks every 4, bit every 64
    applyStimulus(0, 0, 0, 1, 3, 0);
    checkOutput("t1_wr_disabled_pending", int'(div_pending), 0);
    div_wr = 1'b0;
    en     = 1'b1;
    total = 0;
    earlyBits = 0;
    lastBit = 0;
    for (int i = 1; i <= 16; i++) begin
      waitTick(p);
      total += p;
      if (i == 1) checkOutput("t1_first_period", p, 4);
      if (i < 16) earlyBits += int'(tick_bit);
      else lastBit = int'(tick_bit);
    end
    checkOutput("t1_16_ticks_cycles", total, 64);
    checkOutput("t1_early_bit_ticks", earlyBits, 0);
    checkOutput("t1_bit_on_16th", lastBit, 1);

    // Test 2: div 3/8 from a sync, periods 4,4,5,4,5..., 32 ticks in 144
    applyStimulus(0, 0, 0, 1, 3, 8);
    applyStimulus(0, 0, 1, 0, 0, 0);
    sync = 1'b0;
    en   = 1'b1;
    waitTick(p);
    checkOutput("t2_first_period", p, 4);
    total = 0;
    for (int i = 1; i <= 32; i++) begin
      waitTick(p);
      total += p;
      if (i == 1) checkOutput("t2_period_a", p, 4);
      if (i == 2) checkOutput("t2_period_b", p, 5);
    end
    checkOutput("t2_32_ticks_cycles", total, 144);

    // Test 3: mid-period write to 9 stays pending until the next wrap
    applyStimulus(0, 0, 0, 1, 3, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    sync = 1'b0;
    en   = 1'b1;
    waitTick(p);
    checkOutput("t3_setup_period", p, 4);
    applyStimulus(0, 1, 0, 1, 9, 0);
    checkOutput("t3_pending_set", int'(div_pending), 1);
    div_wr = 1'b0;
    waitTick(p);
    checkOutput("t3_current_period", p + 1, 4);
    checkOutput("t3_pending_cleared", int'(div_pending), 0);
    waitTick(p);
    checkOutput("t3_new_period_1", p, 10);
    waitTick(p);
    checkOutput("t3_new_period_2", p, 10);

    // Test 4: en low for 7 cycles with cnt = 2 holds the count
    applyStimulus(0, 0, 0, 1, 3, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    osCount = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      osCount += int'(tick_os);
    end
    checkOutput("t4_ticks_while_disabled", osCount, 0);
    en = 1'b1;
    waitTick(p);
    checkOutput("t4_resume_period", p, 2);

    // Test 5: sync on a wrap edge suppresses the tick and restarts os_cnt
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("t5_no_tick_after_sync", int'(tick_os), 0);
    sync = 1'b0;
    waitTick(p);
    checkOutput("t5_period_after_sync", p, 4);
    earlyBits = int'(tick_bit);
    lastBit = 0;
    for (int i = 2; i <= 16; i++) begin
      waitTick(p);
      if (i < 16) earlyBits += int'(tick_bit);
      else lastBit = int'(tick_bit);
    end
    checkOutput("t5_early_bit_ticks", earlyBits, 0);
    checkOutput("t5_bit_on_16th", lastBit, 1);

    // Zero divisor: tick_os high on every enabled cycle
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    osCount = 0;
    bitCount = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      osCount += int'(tick_os);
      bitCount += int'(tick_bit);
    end
    checkOutput("zero_div_os_ticks", osCount, 32);
    checkOutput("zero_div_bit_ticks", bitCount, 2);

    // Test 6: reset while a write is pending restores 324/8
    applyStimulus(0, 0, 0, 1, 3, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 9, 0);
    checkOutput("t6_pending_before_reset", int'(div_pending), 1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("t6_reset_tick_os", int'(tick_os), 0);
    checkOutput("t6_reset_tick_bit", int'(tick_bit), 0);
    checkOutput("t6_reset_pending", int'(div_pending), 0);
    reset = 1'b0;
    waitTick(p);
    checkOutput("t6_first_period", p, 325);
    waitTick(p);
    checkOutput("t6_second_period", p, 325);
    waitTick(p);
    checkOutput("t6_third_period", p, 326);

    checkOutput("bit_without_os", orphanBits, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
